// File: rtl/dht11_meas_sched.sv
// DHT11 measurement scheduler: periodic or on-demand read launch, minimum
// inter-read gap, read timeout, checksum verification with bounded retries,
// and latched humidity/temperature/status for the display path.
//
// Handshake: rd_start is a one-cycle pulse; the reader answers with a
// one-cycle rd_done pulse carrying rd_data. rd_done is only accepted in
// WAIT. req_now is level- or pulse-sensitive and is never dropped: it
// latches into a pending flag that is serviced from IDLE once the gap elapses.
module dht11_meas_sched #(
    parameter int TICK_DIV   = 100_000,
    parameter int PERIOD_MS  = 2000,
    parameter int MIN_GAP_MS = 1100,
    parameter int TIMEOUT_MS = 30,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        req_now,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic [39:0] rd_data,
    output logic [7:0]  humidity,
    output logic [7:0]  temperature,
    output logic        data_valid,
    output logic        err_flag,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   PERIOD_C   = 16'(PERIOD_MS);
    localparam logic [15:0]   GAP_C      = 16'(MIN_GAP_MS);
    localparam logic [15:0]   TIMEOUT_C  = 16'(TIMEOUT_MS);
    localparam logic [2:0]    MAXR_C     = 3'(MAX_RETRY);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [15:0]   ms_cnt_q;
    logic [2:0]    retry_q, retry_d;
    logic          pend_q, pend_d;
    logic [39:0]   data_q, data_d;
    logic [7:0]    hum_q, hum_d;
    logic [7:0]    tmp_q, tmp_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          ms_tick;
    logic [7:0]    sum_c;

    assign ms_tick = (presc_q == PRESC_LAST);
    assign sum_c   = data_q[39:32] + data_q[31:24] + data_q[23:16] + data_q[15:8];

    // Free-running millisecond prescaler.
    always_ff @(posedge clk) begin
        if (reset_p || ms_tick) presc_q <= '0;
        else                    presc_q <= presc_q + PW'(1);
    end

    // Per-state millisecond counter: restarts on every state change, saturates.
    always_ff @(posedge clk) begin
        if (reset_p || (state_d != state_q)) ms_cnt_q <= '0;
        else if (ms_tick && (ms_cnt_q != 16'hFFFF)) ms_cnt_q <= ms_cnt_q + 16'd1;
    end

    // Next-state, retry, pending-request and result-register logic.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        pend_d  = pend_q | req_now;
        data_d  = data_q;
        hum_d   = hum_q;
        tmp_d   = tmp_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if ((ms_cnt_q == PERIOD_C) || (pend_d && (ms_cnt_q >= GAP_C)))
                    state_d = S_START;
            end
            S_START: begin
                // A request arriving in the very start cycle stays pending.
                pend_d  = req_now;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // rd_done has priority over a coincident timeout.
                if (rd_done) begin
                    data_d  = rd_data;
                    state_d = S_CHECK;
                end else if (ms_cnt_q == TIMEOUT_C) begin
                    state_d = S_FAIL;
                end
            end
            S_CHECK: begin
                if (sum_c == data_q[7:0]) begin
                    hum_d   = data_q[39:32];
                    tmp_d   = data_q[23:16];
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    retry_d = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (retry_q < MAXR_C) begin
                    retry_d = retry_q + 3'd1;
                    state_d = S_GAP;
                end else begin
                    // Last good humidity/temperature are kept on exhaustion.
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    retry_d = 3'd0;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (ms_cnt_q == GAP_C) state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= S_IDLE;
            retry_q <= 3'd0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            hum_q   <= '0;
            tmp_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            hum_q   <= hum_d;
            tmp_q   <= tmp_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign rd_start    = (state_q == S_START);
    assign humidity    = hum_q;
    assign temperature = tmp_q;
    assign data_valid  = valid_q;
    assign err_flag    = err_q;
    assign busy        = (state_q != S_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_dht11_meas_sched.sv
// Directed bench for dht11_meas_sched with a scaled-down timebase
// (10 clk per ms, 20 ms period, 5 ms gap, 3 ms timeout, 2 retries).
module tb_dht11_meas_sched;

    logic        clk;
    logic        reset_p;
    logic        req_now;
    logic        rd_start;
    logic        rd_done;
    logic [39:0] rd_data;
    logic [7:0]  humidity;
    logic [7:0]  temperature;
    logic        data_valid;
    logic        err_flag;
    logic        busy;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [39:0] GOOD1 = 40'h37_00_1A_00_51;
    localparam logic [39:0] BAD1  = 40'h37_00_1A_00_52;
    localparam logic [39:0] GOOD2 = 40'h40_05_15_02_5C;

    dht11_meas_sched #(
        .TICK_DIV(10), .PERIOD_MS(20), .MIN_GAP_MS(5), .TIMEOUT_MS(3), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .reset_p(reset_p), .req_now(req_now), .rd_start(rd_start),
        .rd_done(rd_done), .rd_data(rd_data), .humidity(humidity),
        .temperature(temperature), .data_valid(data_valid), .err_flag(err_flag),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input int d, input int lo, input int hi);
        check_eq($sformatf("%s delta=%0d range=[%0d,%0d]", tag, d, lo, hi),
                 40'(d >= lo && d <= hi), 40'd1);
    endtask

    // Wait (bounded) for an rd_start pulse; returns the cycle stamp.
    task automatic wait_start(input string tag, input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (rd_start) begin
                at = cyc;
                break;
            end
        end
        check_eq({tag, "_seen"}, 40'(at >= 0), 40'd1);
    endtask

    // One-cycle rd_done pulse; returns on the negedge it drops.
    task automatic pulse_done(input logic [39:0] v);
        rd_data = v;
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] h, input logic [7:0] t,
                                input logic v, input logic e);
        check_eq({tag, "_hum"},   40'(humidity),    40'(h));
        check_eq({tag, "_tmp"},   40'(temperature), 40'(t));
        check_eq({tag, "_valid"}, 40'(data_valid),  40'(v));
        check_eq({tag, "_err"},   40'(err_flag),    40'(e));
    endtask

    initial begin
        int t_s, t_s2, t_done, t_req, t_rel, t_ent;
        reset_p = 1'b1;
        req_now = 1'b0;
        rd_done = 1'b0;
        rd_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_state", 40'(state_dbg), 40'd0);
        check_eq("rst_busy",  40'(busy),      40'd0);
        check_eq("rst_start", 40'(rd_start),  40'd0);
        check_result("rst", 8'h00, 8'h00, 1'b0, 1'b0);

        // First automatic start ~200 clk after reset release
        reset_p = 1'b0;
        t_rel = cyc;
        wait_start("first", 260, t_s);
        check_range("first_start", t_s - t_rel, 190, 210);
        check_eq("start_busy", 40'(busy), 40'd1);
        @(negedge clk);
        check_eq("start_one_cycle", 40'(rd_start), 40'd0);
        check_eq("wait_state", 40'(state_dbg), 40'd2);

        // Good read
        repeat (9) @(negedge clk);
        t_done = cyc;
        pulse_done(GOOD1);
        @(negedge clk);
        check_result("good1", 8'h37, 8'h1A, 1'b1, 1'b0);
        check_eq("good1_idle", 40'(state_dbg), 40'd0);

        // Next automatic start, then bad checksum -> retry after the gap
        wait_start("auto2", 260, t_s);
        check_range("auto2_period", t_s - t_done, 185, 215);
        repeat (10) @(negedge clk);
        t_done = cyc;
        pulse_done(BAD1);
        @(negedge clk);
        check_result("bad_hold", 8'h37, 8'h1A, 1'b1, 1'b0);
        wait_start("retry", 100, t_s2);
        check_range("retry_gap", t_s2 - t_done, 40, 60);
        repeat (10) @(negedge clk);
        t_done = cyc;
        pulse_done(GOOD2);
        @(negedge clk);
        check_result("good2", 8'h40, 8'h15, 1'b1, 1'b0);

        // Hung reads: 3 starts, then error with last good values kept
        wait_start("auto3", 260, t_s);
        check_range("auto3_period", t_s - t_done, 185, 215);
        wait_start("to_retry1", 120, t_s2);
        check_range("to_retry1", t_s2 - t_s, 60, 90);
        wait_start("to_retry2", 120, t_s);
        check_range("to_retry2", t_s - t_s2, 60, 90);
        t_ent = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (err_flag) begin
                t_ent = cyc;
                break;
            end
        end
        check_eq("err_seen", 40'(t_ent >= 0), 40'd1);
        check_result("exhaust", 8'h40, 8'h15, 1'b0, 1'b1);
        check_eq("exhaust_idle", 40'(state_dbg), 40'd0);

        // Manual request shortly after: deferred until the gap elapses
        repeat (20) @(negedge clk);
        req_now = 1'b1;
        t_req = cyc;
        @(negedge clk);
        req_now = 1'b0;
        wait_start("req", 60, t_s);
        check_range("req_defer", t_s - t_req, 20, 33);

        // Request while busy -> serviced from IDLE after the gap
        repeat (2) @(negedge clk);
        req_now = 1'b1;
        @(negedge clk);
        req_now = 1'b0;
        check_eq("req_busy", 40'(busy), 40'd1);
        repeat (3) @(negedge clk);
        t_done = cyc;
        pulse_done(GOOD1);
        @(negedge clk);
        check_result("good3", 8'h37, 8'h1A, 1'b1, 1'b0);
        wait_start("pend", 100, t_s2);
        check_range("pend_service", t_s2 - t_done, 40, 56);
        check_eq("min_gap", 40'(t_s2 - t_s >= 41), 40'd1);

        // Reset in WAIT clears everything, including the pending request
        repeat (3) @(negedge clk);
        check_eq("pre_rst_wait", 40'(state_dbg), 40'd2);
        req_now = 1'b1;
        @(negedge clk);
        req_now = 1'b0;
        reset_p = 1'b1;
        @(negedge clk);
        check_eq("midrst_state", 40'(state_dbg), 40'd0);
        check_eq("midrst_start", 40'(rd_start),  40'd0);
        check_eq("midrst_busy",  40'(busy),      40'd0);
        check_result("midrst", 8'h00, 8'h00, 1'b0, 1'b0);
        reset_p = 1'b0;
        t_rel = cyc;
        pulse_done(GOOD1);
        repeat (2) @(negedge clk);
        check_result("late_done", 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("late_done_state", 40'(state_dbg), 40'd0);
        wait_start("post_rst", 260, t_s);
        check_range("post_rst_start", t_s - t_rel, 190, 210);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
